// File: rtl/zbus_arb.sv
// zbus_arb: round-robin arbiter sharing one zbus output port among RN requesters (burst locking when ZBUS_ARB_BURST_EN is defined)
module zbus_arb #(
    parameter int BW  = 8,
    parameter int RN  = 4,
    parameter int BL  = 4,
    parameter int RNL = $clog2(RN),
    parameter int BLL = (BL > 1) ? $clog2(BL) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RN-1:0]    zi_vld,
    input  logic [RN*BW-1:0] zi_bus,
    output logic [RN-1:0]    zi_ack,
    output logic             zo_vld,
    output logic [BW-1:0]    zo_bus,
    output logic [RNL-1:0]   zo_sel,
    input  logic             zo_ack
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state_q, state_d;
    logic [RNL-1:0] gnt_q, gnt_d, ptr_q, ptr_d, nxt_ptr, pick;
    logic trn, last, rel, go;
`ifdef ZBUS_ARB_BURST_EN
    logic [BLL-1:0] cnt_q, cnt_d;
`else
    logic [BLL-1:0] unused_bl;
    assign unused_bl = BLL'(BL);
`endif

    function automatic logic [RNL-1:0] rr_pick(input logic [RN-1:0] v, input logic [RNL-1:0] s);
        int idx;
        rr_pick = s;
        for (int i = RN - 1; i >= 0; i--) begin
            idx = (int'(s) + i) % RN;
            if (v[idx]) rr_pick = RNL'(idx);
        end
    endfunction

    // Mux the granted requester onto the output port and decide whether the grant is released
    always_comb begin
        zo_sel  = gnt_q;
        zo_bus  = zi_bus[int'(gnt_q)*BW +: BW];
        zo_vld  = (state_q == BUSY) && zi_vld[gnt_q];
        zi_ack  = (state_q == BUSY) ? (RN'(zo_ack) << gnt_q) : '0;
        trn     = zo_vld & zo_ack;
`ifdef ZBUS_ARB_BURST_EN
        last    = cnt_q == BLL'(BL - 1);
`else
        last    = 1'b1;
`endif
        rel     = (state_q == BUSY) && (!zi_vld[gnt_q] || (trn && last));
        nxt_ptr = rel ? ((int'(gnt_q) == RN - 1) ? '0 : gnt_q + 1'b1) : ptr_q;
        pick    = rr_pick(zi_vld, nxt_ptr);
    end

    // Next grant: re-arbitrate from IDLE or on release, using the already-advanced pointer
    always_comb begin
        go      = (state_q == IDLE) || rel;
        state_d = go ? ((|zi_vld) ? BUSY : IDLE) : state_q;
        gnt_d   = (go && (|zi_vld)) ? pick : gnt_q;
        ptr_d   = nxt_ptr;
`ifdef ZBUS_ARB_BURST_EN
        cnt_d   = go ? '0 : cnt_q + BLL'(trn);
`endif
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
`ifdef ZBUS_ARB_BURST_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
`ifdef ZBUS_ARB_BURST_EN
            cnt_q   <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_zbus_arb.sv
// tb_zbus_arb: randomized self-checking bench for zbus_arb against a behavioural round-robin model
module tb_zbus_arb;
    localparam int BW = 8, RN = 4, BL = 4;
`ifdef ZBUS_ARB_BURST_EN
    localparam int EBL = BL;
`else
    localparam int EBL = 1;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic [RN-1:0] v = '0;
    logic [RN*BW-1:0] b = '0;
    logic a = 1'b0;
    logic [RN-1:0] zi_ack;
    logic zo_vld;
    logic [BW-1:0] zo_bus;
    logic [1:0] zo_sel;
    int total = 0, bad = 0;

    int m_busy, m_gnt, m_ptr, m_cnt;
    logic e_vld;
    logic [1:0] e_sel;
    logic [RN-1:0] e_ack;
    logic [BW-1:0] e_bus;

    zbus_arb #(.BW(BW), .RN(RN), .BL(BL)) dut (
        .clk(clk), .rst(rst), .zi_vld(v), .zi_bus(b), .zi_ack(zi_ack),
        .zo_vld(zo_vld), .zo_bus(zo_bus), .zo_sel(zo_sel), .zo_ack(a)
    );

    always #5 clk = ~clk;

    function automatic int scan(input logic [RN-1:0] vv, input int p);
        for (int k = 0; k < RN; k++) if (vv[(p + k) % RN]) return (p + k) % RN;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_gnt = 0; m_ptr = 0; m_cnt = 0;
    endtask

    task automatic model_eval();
        e_sel = 2'(m_gnt);
        e_vld = (m_busy != 0) && v[m_gnt];
        e_ack = m_busy != 0 ? RN'(a) << m_gnt : '0;
        e_bus = b[m_gnt*BW +: BW];
    endtask

    task automatic model_adv();
        bit t;
        t = e_vld && a;
        if (m_busy == 0) begin
            if (v != 0) begin m_gnt = scan(v, m_ptr); m_cnt = 0; m_busy = 1; end
        end else if (!v[m_gnt] || (t && m_cnt == EBL - 1)) begin
            m_ptr = (m_gnt + 1) % RN;
            if (v != 0) begin m_gnt = scan(v, m_ptr); m_cnt = 0; end
            else m_busy = 0;
        end else if (t) m_cnt++;
    endtask

    task automatic drive(input logic [RN-1:0] vv, input logic aa);
        v = vv; b = {$urandom, $urandom}; a = aa;
        #1;
        model_eval();
    endtask

    task automatic adv();
        @(posedge clk);
        model_adv();
        @(negedge clk);
    endtask

    task automatic do_reset();
        v = '0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; v = '0; a = 1'b1;
        @(negedge clk);
        total++;
        if (zo_vld !== 1'b0 || zi_ack !== '0 || zo_sel !== 2'd0) begin
            bad++; $display("FAIL reset_hold vld=%b ack=%b sel=%0d want 0/0/0", zo_vld, zi_ack, zo_sel);
        end
        rst = 1'b0; model_reset();
        for (int i = 0; i < 2; i++) begin
            drive(4'b0000, 1'b1);
            total++;
            if (zo_vld !== 1'b0 || zi_ack !== '0 || zo_sel !== 2'd0) begin
                bad++; $display("FAIL reset_idle vld=%b ack=%b sel=%0d want 0/0/0", zo_vld, zi_ack, zo_sel);
            end
            adv();
        end
        drive(4'b0100, 1'b0);
        total++;
        if (zo_vld !== 1'b0) begin bad++; $display("FAIL latency_t vld=%b want 0", zo_vld); end
        adv();
        drive(4'b0100, 1'b0);
        total++;
        if (zo_vld !== 1'b1 || zo_sel !== 2'd2 || zo_bus !== b[2*BW +: BW]) begin
            bad++; $display("FAIL latency_t1 vld=%b sel=%0d bus=%h want 1/2/%h", zo_vld, zo_sel, zo_bus, b[2*BW +: BW]);
        end
        adv();
    endtask

    task automatic test_burst_rr();
        int s;
        do_reset();
        for (int k = 0; k <= 8 * EBL + 2; k++) begin
            drive(4'b1111, 1'b1);
            s = (k - 1) / EBL % RN;
            total++;
            if (k == 0 ? zo_vld !== 1'b0 :
                (zo_vld !== 1'b1 || zo_sel !== 2'(s) || zi_ack !== RN'(1 << s) || zo_bus !== b[s*BW +: BW])) begin
                bad++; $display("FAIL burst_rr k=%0d vld=%b sel=%0d ack=%b want sel=%0d", k, zo_vld, zo_sel, zi_ack, s);
            end
            adv();
        end
    endtask

    task automatic test_early_release();
        logic [RN-1:0] pat [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b1000};
        logic [1:0] ws [5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd3};
        logic wv [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(pat[k], 1'b1);
            total++;
            if (zo_vld !== wv[k] || (k > 0 && zo_sel !== ws[k]) || zi_ack !== e_ack) begin
                bad++; $display("FAIL early_rel k=%0d vld=%b sel=%0d ack=%b want %b/%0d/%b", k, zo_vld, zo_sel, zi_ack, wv[k], ws[k], e_ack);
            end
            adv();
        end
    endtask

    task automatic test_ack_hold();
        do_reset();
        drive(4'b1111, 1'b0);
        adv();
        for (int k = 0; k < 10; k++) begin
            drive(4'b1111, 1'b0);
            total++;
            if (zo_vld !== 1'b1 || zi_ack !== '0 || zo_sel !== 2'd0) begin
                bad++; $display("FAIL ack_hold k=%0d vld=%b ack=%b sel=%0d want 1/0000/0", k, zo_vld, zi_ack, zo_sel);
            end
            adv();
        end
        for (int k = 0; k <= EBL; k++) begin
            drive(4'b1111, 1'b1);
            total++;
            if (zo_sel !== (k < EBL ? 2'd0 : 2'd1) || zo_vld !== 1'b1) begin
                bad++; $display("FAIL ack_burst k=%0d sel=%0d vld=%b want %0d/1", k, zo_sel, zo_vld, k < EBL ? 0 : 1);
            end
            adv();
        end
    endtask

    task automatic test_alternate();
        int s;
        do_reset();
        drive(4'b0101, 1'b1);
        adv();
        for (int k = 0; k < 4 * EBL + 1; k++) begin
            drive(4'b0101, 1'b1);
            s = (k / EBL) % 2 * 2;
            total++;
            if (zo_sel !== 2'(s) || zo_vld !== 1'b1 || zi_ack !== RN'(1 << s)) begin
                bad++; $display("FAIL alternate k=%0d sel=%0d vld=%b ack=%b want sel=%0d", k, zo_sel, zo_vld, zi_ack, s);
            end
            adv();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 2 * EBL + 1 + (EBL > 1 ? 1 : 0); k++) begin
            drive(4'b1111, 1'b1);
            adv();
        end
        drive(4'b1111, 1'b1);
        total++;
        if (zo_sel !== 2'd2) begin bad++; $display("FAIL mid_pre sel=%0d want 2", zo_sel); end
        rst = 1'b1;
        #1;
        total++;
        if (zo_vld !== 1'b0 || zi_ack !== '0 || zo_sel !== 2'd0) begin
            bad++; $display("FAIL mid_rst vld=%b ack=%b sel=%0d want 0/0/0", zo_vld, zi_ack, zo_sel);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(4'b1111, 1'b1);
        adv();
        for (int k = 0; k <= EBL; k++) begin
            drive(4'b1111, 1'b1);
            total++;
            if (zo_sel !== (k < EBL ? 2'd0 : 2'd1) || zo_vld !== 1'b1) begin
                bad++; $display("FAIL mid_after k=%0d sel=%0d vld=%b want %0d/1", k, zo_sel, zo_vld, k < EBL ? 0 : 1);
            end
            adv();
        end
    endtask

    task automatic test_random();
        logic [RN-1:0] vv;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            vv = ($urandom_range(0, 3) == 0) ? '0 : RN'($urandom);
            drive(vv, 1'($urandom_range(0, 3) != 0));
            total++;
            if (zo_sel !== e_sel || zo_vld !== e_vld || zi_ack !== e_ack || (e_vld && zo_bus !== e_bus)) begin
                bad++; $display("FAIL random k=%0d sel=%0d/%0d vld=%b/%b ack=%b/%b bus=%h/%h", k, zo_sel, e_sel, zo_vld, e_vld, zi_ack, e_ack, zo_bus, e_bus);
            end
            adv();
        end
    endtask

    initial begin
        test_reset();
        test_burst_rr();
        test_early_release();
        test_ack_hold();
        test_alternate();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/zbus_arb.md
# zbus_arb

Round-robin arbiter that shares one zbus output port, typically the write port of a zbus FIFO, between `RN` zbus requester ports. Grant is registered and held for a burst of up to `BL` transfers. It is released early when the granted requester drops `zi_vld`. On release the grant passes directly to the next requester without a bubble cycle. All logic is single-clock; the output port's `zo_ack` is forwarded combinationally to the granted requester only.

## Interface
- `BW`, 8: bus width of grouped zbus signals per port.
- `RN`, 4: number of requester ports; legal range 2 and up.
- `BL`, 4: maximum transfers per grant (burst length); legal range 1 and up.
- `RNL`, `$clog2(RN)`: grant index width.
- `BLL`, `$clog2(BL)` with a minimum of 1: burst counter width.

Ports (clock and reset first):
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous reset, active-high.
- `zi_vld`, in, RN: per-requester transfer valid; bit r belongs to requester r.
- `zi_bus`, in, RN*BW: per-requester grouped bus; requester r occupies `[r*BW +: BW]`.
- `zi_ack`, out, RN: per-requester transfer acknowledge.
- `zo_vld`, out, 1: output transfer valid.
- `zo_bus`, out, BW: output grouped bus signals.
- `zo_sel`, out, RNL: index of the currently granted requester.
- `zo_ack`, in, 1: output transfer acknowledge. It may be asserted independently of `zo_vld`.

## Operation
- A transfer on a port occurs in any cycle where vld and ack are both 1; `zo_trn = zo_vld & zo_ack`.
- Registers:
  - state: IDLE or BUSY.
  - `gnt`: RNL bits.
  - `ptr`: RNL bits, the round-robin start index.
  - `cnt`: BLL bits, transfers done in the current grant.
- Round-robin pick: the first r with `zi_vld[r]=1`, scanning `ptr, ptr+1, … RN-1, 0, … ptr-1` with modulo-RN wrap.
- IDLE state:
  - Outputs: `zo_vld=0`, `zi_ack=0`.
  - If any `zi_vld` is set: next cycle `gnt` = pick, `cnt=0`, state becomes BUSY.
- BUSY state, datapath:
  - `zo_vld = zi_vld[gnt]`.
  - `zo_bus = zi_bus[gnt]`.
  - `zi_ack[gnt] = zo_ack`; all other `zi_ack` bits are 0.
- BUSY state, release condition: `zi_vld[gnt]=0`, or `zo_trn` with `cnt==BL-1`.
- BUSY state, when not releasing: `cnt` increments on each `zo_trn`.
- BUSY state, on release:
  - `ptr` is set to `(gnt+1) mod RN`.
  - Pick is evaluated with this new `ptr` against the current-cycle `zi_vld`.
  - If a requester is found: `gnt` = pick, `cnt=0`, state stays BUSY.
  - Otherwise: state becomes IDLE.
  - The releasing requester is eligible again, but only at lowest priority.
- `zo_sel = gnt` in all states. `zo_bus = zi_bus[gnt]` also in IDLE; it is a don't-care there.
- `gnt` never changes while BUSY except on release.

## Timing
- Reset values: state IDLE, `gnt=0`, `ptr=0`, `cnt=0`, `zo_vld=0`, `zi_ack=0`, `zo_sel=0`.
- Reset is honoured mid-burst: all registers clear immediately and no transfer completes in the reset cycle.
- Latency from IDLE: a request in cycle t produces `zo_vld` in cycle t+1.
- Grant hand-over between requesters costs no bubble.
- `zo_vld` and `zo_bus` are combinational from `zi_vld`/`zi_bus` of the granted port.
- `zi_ack` is combinational from `zo_ack`. There is no path from `zo_ack` to `zo_vld`.
- Burst boundary: exactly BL transfers complete, then the grant moves in the same cycle as the last transfer.
- `BL=1`: every transfer releases, giving pure per-transfer round-robin.
- Simultaneous requests with `ptr=0`: requesters are served in order 0, 1, 2, …

## Configuration
- Macro: `ZBUS_ARB_BURST_EN`.
- Defined: burst locking as above, with up to BL transfers per grant.
- Undefined:
  - `cnt` is not implemented.
  - `BL` is ignored and the grant releases after every `zo_trn`, as well as on `zi_vld[gnt]=0`.
  - Behaviour is identical to the defined case with `BL=1`.

## Test plan
- Reset, then `zi_vld=4'b0000`: `zo_vld=0`, `zi_ack=0`, `zo_sel=0`. Assert `zi_vld[2]=1` at t: `zo_sel=2`, `zo_vld=1` at t+1.
- `zi_vld=4'b1111`, `zo_ack=1` held, BL=4, burst enabled: `zo_sel` sequence is 0×4, 1×4, 2×4, 3×4, 0…, with no idle cycle between bursts.
- Requester 1 alone issues 2 transfers, then drops `zi_vld[1]` while `zi_vld[3]=1`: the grant moves to 3 in that cycle and `zo_sel=3` on the next cycle.
- Grant held by 0 with `zo_ack=0` for 10 cycles: `zo_vld=1`, `zi_ack=0`, `cnt` unchanged, and `zo_sel` stays 0 despite the other requests.
- Macro undefined, `zi_vld=4'b0101`, `zo_ack=1`: `zo_sel` alternates 0, 2, 0, 2 on every transfer.
- `rst` pulsed in the middle of a burst on requester 2, all requests held: the cycle after reset release, the grant goes to 0 (`ptr=0`) with `cnt=0`.
